// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX mouse-protocol encoder.
package msx_mouse_pkg;

    typedef enum logic [1:0] {
        X_HI = 2'd0,
        X_LO = 2'd1,
        Y_HI = 2'd2,
        Y_LO = 2'd3
    } nib_state_t;

    localparam logic [3:0] NIB_IDLE = 4'hF;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'sh7F;
        end else if (v < -32'sd128) begin
            return 8'sh80;
        end else begin
            return signed'(v[7:0]);
        end
    endfunction

endpackage

// File: rtl/msx_delta_accum.sv
// Per-axis saturating delta accumulator with snapshot-and-clear.
module msx_delta_accum
    import msx_mouse_pkg::*;
#(
    parameter int IN_W = 9,
    parameter int INV  = 0
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            upd,
    input  logic            snap,
    input  logic [IN_W-1:0] delta,
    output logic [7:0]      snap_nxt
);

    localparam int SW = IN_W + 2;

    logic signed [7:0]    acc_q, acc_d;
    logic signed [7:0]    snap_q, snap_d;
    logic signed [SW-1:0] d_ext, d_eff, base, sum;

    always_comb begin
        d_ext  = {{2{delta[IN_W-1]}}, delta};
        d_eff  = (INV != 0) ? -d_ext : d_ext;
        // A snapshot hands the old total to snap and restarts from zero, so a
        // coincident delta lands in the fresh accumulator.
        base   = snap ? '0 : SW'(acc_q);
        sum    = base + d_eff;
        acc_d  = acc_q;
        snap_d = snap_q;
        if (snap) begin
            snap_d = acc_q;
            acc_d  = '0;
        end
        if (upd) begin
            acc_d = sat8(32'(sum));
        end
        if (clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign snap_nxt = snap_d;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX mouse encoder for one joystick port: enable control, strobe edge detect,
// inter-nibble timeout and the nibble mux over two per-axis accumulators.
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT  = 100000,
    parameter int IN_W     = 9,
    parameter int INVERT_X = 1,
    parameter int INVERT_Y = 0
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic [IN_W-1:0] mouse_x,
    input  logic [IN_W-1:0] mouse_y,
    input  logic [1:0]      mouse_btn,
    input  logic            mouse_strobe,
    input  logic            joy_active,
    input  logic            strobe,
    output logic            enable,
    output logic [5:0]      port_out,
    output logic [1:0]      state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    logic          enable_q, enable_d;
    logic          strobe_dly_q;
    nib_state_t    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    nib_q, nib_d;
    logic [1:0]    btn_q, btn_d;
    logic          stb_edge, snap;
    logic [7:0]    snap_x_nxt, snap_y_nxt;

    always_comb begin
        enable_d = enable_q;
        if (mouse_strobe) begin
            enable_d = 1'b1;
        end else if (joy_active) begin
            enable_d = 1'b0;
        end

        stb_edge = strobe ^ strobe_dly_q;
        btn_d    = ~mouse_btn;
        state_d  = state_q;
        tmo_d    = tmo_q;
        nib_d    = nib_q;
        snap     = 1'b0;

        if (!enable_d) begin
            state_d = X_HI;
            tmo_d   = '0;
            nib_d   = NIB_IDLE;
        end else begin
            if (tmo_q != '0) begin
                tmo_d = tmo_q - TW'(1);
            end
            if (tmo_q == TW'(1)) begin
                state_d = X_HI;
            end
            // An edge overrides a timeout expiring in the same cycle.
            if (stb_edge && enable_q) begin
                state_d = nib_state_t'(state_q + 2'd1);
                tmo_d   = TMO_LOAD;
                case (state_q)
                    X_HI: begin
                        snap  = 1'b1;
                        nib_d = snap_x_nxt[7:4];
                    end
                    X_LO: nib_d = snap_x_nxt[3:0];
                    Y_HI: nib_d = snap_y_nxt[7:4];
                    Y_LO: nib_d = snap_y_nxt[3:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            enable_q     <= 1'b0;
            strobe_dly_q <= strobe;
            state_q      <= X_HI;
            tmo_q        <= '0;
            nib_q        <= NIB_IDLE;
            btn_q        <= 2'b11;
        end else begin
            enable_q     <= enable_d;
            strobe_dly_q <= strobe;
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            nib_q        <= nib_d;
            btn_q        <= btn_d;
        end
    end

    msx_delta_accum #(.IN_W(IN_W), .INV(INVERT_X)) u_acc_x (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .clr      (~enable_d),
        .upd      (mouse_strobe),
        .snap     (snap),
        .delta    (mouse_x),
        .snap_nxt (snap_x_nxt)
    );

    msx_delta_accum #(.IN_W(IN_W), .INV(INVERT_Y)) u_acc_y (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .clr      (~enable_d),
        .upd      (mouse_strobe),
        .snap     (snap),
        .delta    (mouse_y),
        .snap_nxt (snap_y_nxt)
    );

    assign enable   = enable_q;
    assign port_out = {btn_q, nib_q};
    assign state    = state_q;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed bench for msx_mouse_port: table of read transactions plus corner sequences.
module tb_msx_mouse_port;

    localparam int TMO  = 20;
    localparam int IN_W = 9;

    logic            clk_sys = 1'b0;
    logic            rst_n;
    logic [IN_W-1:0] mouse_x, mouse_y;
    logic [1:0]      mouse_btn;
    logic            mouse_strobe, joy_active, strobe;
    logic            enable;
    logic [5:0]      port_out;
    logic [1:0]      state;

    int n_tests = 0;
    int n_fail  = 0;

    msx_mouse_port #(.TIMEOUT(TMO), .IN_W(IN_W), .INVERT_X(1), .INVERT_Y(0)) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btn    (mouse_btn),
        .mouse_strobe (mouse_strobe),
        .joy_active   (joy_active),
        .strobe       (strobe),
        .enable       (enable),
        .port_out     (port_out),
        .state        (state)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int              npulse;
        logic [IN_W-1:0] x;
        logic [IN_W-1:0] y;
        logic [1:0]      btn;
        logic [15:0]     nibs;
        logic [1:0]      btn_exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y);
        mouse_x      = x;
        mouse_y      = y;
        mouse_strobe = 1'b1;
        @(negedge clk_sys);
        mouse_strobe = 1'b0;
    endtask

    task automatic toggle();
        strobe = ~strobe;
        @(negedge clk_sys);
    endtask

    task automatic read4(input string name, input logic [15:0] nibs);
        logic [15:0] e;
        e = nibs;
        for (int k = 0; k < 4; k++) begin
            toggle();
            chk($sformatf("%s nib%0d", name, k), 32'(port_out[3:0]), 32'(e[15-4*k -: 4]));
            chk($sformatf("%s state%0d", name, k), 32'(state), 32'((k + 1) % 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1,  9'd5,    9'd3,    2'b01, 16'hFB03, 2'b10};
        vecs[1] = '{40, 9'd10,   9'd0,    2'b10, 16'h8000, 2'b01};
        vecs[2] = '{40, 9'h1F6,  9'd10,   2'b11, 16'h7F7F, 2'b00};
        vecs[3] = '{1,  9'h100,  9'h100,  2'b00, 16'h7F80, 2'b11};
        vecs[4] = '{3,  9'd1,    9'h1FF,  2'b00, 16'hFDFD, 2'b11};
        vecs[5] = '{2,  9'h1C0,  9'h040,  2'b01, 16'h7F7F, 2'b10};
        vecs[6] = '{1,  9'd128,  9'h181,  2'b00, 16'h8081, 2'b11};

        rst_n = 1'b0; mouse_x = '0; mouse_y = '0; mouse_btn = 2'b00;
        mouse_strobe = 1'b0; joy_active = 1'b0; strobe = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset port_out", 32'(port_out), 32'h3F);
        chk("reset enable", 32'(enable), 0);
        chk("reset state", 32'(state), 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        for (int i = 0; i < 7; i++) begin
            mouse_btn = vecs[i].btn;
            if (vecs[i].npulse == 0) @(negedge clk_sys);
            for (int p = 0; p < vecs[i].npulse; p++) pulse(vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d enable", i), 32'(enable), 1);
            read4($sformatf("vec%0d", i), vecs[i].nibs);
            chk($sformatf("vec%0d buttons", i), 32'(port_out[5:4]), 32'(vecs[i].btn_exp));
        end
        mouse_btn = 2'b00;

        // Abandoned read: timeout returns to X_HI, last nibble is held
        pulse(9'h1EE, 9'd0);
        toggle();
        chk("tmo nib0", 32'(port_out[3:0]), 32'h1);
        toggle();
        chk("tmo nib1", 32'(port_out[3:0]), 32'h2);
        chk("tmo state before", 32'(state), 2);
        repeat (TMO + 2) @(negedge clk_sys);
        chk("tmo state after", 32'(state), 0);
        chk("tmo nib held", 32'(port_out[3:0]), 32'h2);
        pulse(9'h1D0, 9'd5);
        read4("tmo fresh", 16'h3005);

        // Edge on the exact timeout-expiry cycle still advances
        pulse(9'd0, 9'h07E);
        toggle();
        chk("prec nib0", 32'(port_out[3:0]), 32'h0);
        toggle();
        chk("prec state1", 32'(state), 2);
        repeat (TMO - 1) @(negedge clk_sys);
        chk("prec state pre-expiry", 32'(state), 2);
        toggle();
        chk("prec state expiry", 32'(state), 3);
        chk("prec nib expiry", 32'(port_out[3:0]), 32'h7);
        toggle();
        chk("prec nib3", 32'(port_out[3:0]), 32'hE);
        chk("prec wrap", 32'(state), 0);

        // mouse_strobe coincident with the X_HI edge
        pulse(9'h1FE, 9'd2);
        mouse_x = 9'h1FF; mouse_y = 9'd1; mouse_strobe = 1'b1;
        strobe = ~strobe;
        @(negedge clk_sys);
        mouse_strobe = 1'b0;
        chk("coin nib0", 32'(port_out[3:0]), 32'h0);
        chk("coin state0", 32'(state), 1);
        toggle();
        chk("coin nib1", 32'(port_out[3:0]), 32'h2);
        toggle();
        chk("coin nib2", 32'(port_out[3:0]), 32'h0);
        toggle();
        chk("coin nib3", 32'(port_out[3:0]), 32'h2);
        read4("coin next", 16'h0101);

        // joy_active drops mouse mode and clears accumulators
        pulse(9'h1F8, 9'd8);
        joy_active = 1'b1;
        @(negedge clk_sys);
        joy_active = 1'b0;
        chk("joy enable", 32'(enable), 0);
        chk("joy nib", 32'(port_out[3:0]), 32'hF);
        chk("joy state", 32'(state), 0);
        toggle();
        chk("joy edge ignored state", 32'(state), 0);
        chk("joy edge ignored nib", 32'(port_out[3:0]), 32'hF);
        pulse(9'd0, 9'd0);
        chk("joy reenable", 32'(enable), 1);
        read4("joy cleared", 16'h0000);
        joy_active = 1'b1;
        pulse(9'd0, 9'd0);
        joy_active = 1'b0;
        chk("joy+strobe enable", 32'(enable), 1);

        // Reset in the middle of a read
        pulse(9'h1F0, 9'd0);
        toggle();
        toggle();
        chk("rst mid state", 32'(state), 2);
        mouse_btn = 2'b01;
        rst_n = 1'b0;
        @(negedge clk_sys);
        chk("rst mid port_out", 32'(port_out), 32'h3F);
        chk("rst mid enable", 32'(enable), 0);
        chk("rst mid state0", 32'(state), 0);
        rst_n = 1'b1;
        @(negedge clk_sys);
        chk("rst release buttons", 32'(port_out[5:4]), 32'h2);
        pulse(9'h1B0, 9'd0);
        toggle();
        chk("rst first nib", 32'(port_out[3:0]), 32'h5);
        chk("rst first state", 32'(state), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
